video_memory_arbiter: RTL and testbench

Shares the single-port 1024×3-bit video memory between the CPU write path (WVM instruction) and the VGA scan-out reader. VGA reads always win. CPU writes are posted into a small FIFO and drained into RAM on cycles the VGA port leaves free, so the CPU stalls only when the FIFO is full. Sits between the CPU execute stage, the VGA controller and the video RAM macro.

---
 rtl/video_memory_arbiter.sv | 170 +++++++++++++++++
 tb/tb_video_memory_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_memory_arbiter.sv
// video_memory_arbiter
// Shares the single-port video RAM between the CPU write path and the VGA
// scan-out reader. VGA reads always win the RAM port. CPU writes are posted
// into a small circular FIFO and drained on cycles the VGA leaves free, so the
// CPU only stalls when the FIFO is full.
//
// Optional feature: define VIDMEM_CLEAR_EN to build a clear-screen engine that
// fills the whole memory with a latched colour on free cycles.
//
// Ports:
//   clock, reset          system clock (rising edge), async active-high reset
//   iCpuWe/Addr/Data      CPU write request, taken only while oCpuReady=1
//   oCpuReady             FIFO can accept a write this cycle
//   iVgaReq/iVgaAddr      VGA read request, never stalled
//   oVgaData/oVgaValid    read result, one cycle after the request
//   oRamAddr/Data/We      combinational RAM port drive
//   iRamData              RAM synchronous read data
//   iClear/iClearColor    clear-screen start pulse and fill colour
//   oClearBusy            clear in progress (0 when the engine is not built)
module video_memory_arbiter #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 10,
   parameter int DATA_W = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              iCpuWe,
   input  logic [ADDR_W-1:0] iCpuAddr,
   input  logic [DATA_W-1:0] iCpuData,
   output logic              oCpuReady,
   input  logic              iVgaReq,
   input  logic [ADDR_W-1:0] iVgaAddr,
   output logic [DATA_W-1:0] oVgaData,
   output logic              oVgaValid,
   output logic [ADDR_W-1:0] oRamAddr,
   output logic [DATA_W-1:0] oRamData,
   output logic              oRamWe,
   input  logic [DATA_W-1:0] iRamData,
   input  logic              iClear,
   input  logic [DATA_W-1:0] iClearColor,
   output logic              oClearBusy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

   logic [ADDR_W-1:0] fifoAddr [DEPTH];
   logic [DATA_W-1:0] fifoData [DEPTH];
   logic [PTR_W-1:0]  wrPtr;
   logic [PTR_W-1:0]  rdPtr;
   logic [PTR_W:0]    count;
   logic              fifoEmpty;
   logic              clearBusy;
   logic              push;
   logic              pop;

   // Ready depends only on registered state so the CPU never sees a
   // combinational path from its own request or from the VGA request.
   assign fifoEmpty  = (count == '0);
   assign oCpuReady  = (count < FULL_COUNT) && !clearBusy;
   assign push       = iCpuWe && oCpuReady;
   assign pop        = !iVgaReq && !fifoEmpty;
   assign oClearBusy = clearBusy;

   // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + 1'b1;
         if (pop)  rdPtr <= rdPtr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // FIFO storage is plain memory; stale contents are harmless because the
   // count guards every read.
   always_ff @(posedge clock) begin
      if (push) begin
         fifoAddr[wrPtr] <= iCpuAddr;
         fifoData[wrPtr] <= iCpuData;
      end
   end

   // The RAM returns data one cycle after the address, so valid simply
   // follows the request by one cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) oVgaValid <= 1'b0;
      else       oVgaValid <= iVgaReq;
   end

   assign oVgaData = oVgaValid ? iRamData : '0;

`ifdef VIDMEM_CLEAR_EN
   typedef enum logic [1:0] {
      CLR_IDLE,
      CLR_WAIT_DRAIN,
      CLR_FILL
   } clrState_t;

   clrState_t         clrState;
   clrState_t         clrNext;
   logic [ADDR_W-1:0] clearAddr;
   logic [DATA_W-1:0] clearColor;
   logic              fillWrite;

   // The fill only takes cycles nobody else wants; the FIFO is already empty
   // in FILL because enqueue is blocked while busy.
   assign fillWrite = (clrState == CLR_FILL) && !iVgaReq && fifoEmpty;
   assign clearBusy = (clrState != CLR_IDLE);

   // Clear engine next-state: drain queued CPU writes first so they land
   // before the fill, then sweep every address once.
   always_comb begin
      clrNext = clrState;
      case (clrState)
         CLR_IDLE:       if (iClear) clrNext = CLR_WAIT_DRAIN;
         CLR_WAIT_DRAIN: if (fifoEmpty) clrNext = CLR_FILL;
         CLR_FILL:       if (fillWrite && (clearAddr == '1)) clrNext = CLR_IDLE;
         default:        clrNext = CLR_IDLE;
      endcase
   end

   // Clear engine state, fill colour latch and address sweep counter; the
   // counter wraps back to 0 after the last address, ready for the next clear.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         clrState   <= CLR_IDLE;
         clearAddr  <= '0;
         clearColor <= '0;
      end else begin
         clrState <= clrNext;
         if ((clrState == CLR_IDLE) && iClear) clearColor <= iClearColor;
         if (fillWrite) clearAddr <= clearAddr + 1'b1;
      end
   end
`else
   logic unusedClear;

   assign clearBusy   = 1'b0;
   assign unusedClear = ^{iClear, iClearColor};
`endif

   // RAM port mux in fixed priority: VGA read, queued CPU write, clear fill.
   always_comb begin
      oRamAddr = '0;
      oRamData = '0;
      oRamWe   = 1'b0;
      if (iVgaReq) begin
         oRamAddr = iVgaAddr;
      end else if (!fifoEmpty) begin
         oRamAddr = fifoAddr[rdPtr];
         oRamData = fifoData[rdPtr];
         oRamWe   = 1'b1;
`ifdef VIDMEM_CLEAR_EN
      end else if (fillWrite) begin
         oRamAddr = clearAddr;
         oRamData = clearColor;
         oRamWe   = 1'b1;
`endif
      end
   end

endmodule

// File: tb/tb_video_memory_arbiter.sv
// tb_video_memory_arbiter
// Self-checking bench for video_memory_arbiter: a directed vector table, hand
// sequences for reset, starvation and pointer wrap, randomized traffic, and a
// clear-screen sequence when VIDMEM_CLEAR_EN is defined. Expected values come
// from a queue-based model of the posted-write scheme and a reference memory.
module tb_video_memory_arbiter;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 3;
   localparam int MEM_N  = 1 << ADDR_W;
`ifdef VIDMEM_CLEAR_EN
   localparam bit HAS_CLEAR = 1'b1;
`else
   localparam bit HAS_CLEAR = 1'b0;
`endif

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              iCpuWe = 1'b0;
   logic [ADDR_W-1:0] iCpuAddr = '0;
   logic [DATA_W-1:0] iCpuData = '0;
   logic              oCpuReady;
   logic              iVgaReq = 1'b0;
   logic [ADDR_W-1:0] iVgaAddr = '0;
   logic [DATA_W-1:0] oVgaData;
   logic              oVgaValid;
   logic [ADDR_W-1:0] oRamAddr;
   logic [DATA_W-1:0] oRamData;
   logic              oRamWe;
   logic [DATA_W-1:0] iRamData;
   logic              iClear = 1'b0;
   logic [DATA_W-1:0] iClearColor = '0;
   logic              oClearBusy;

   video_memory_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clock(clock), .reset(reset),
      .iCpuWe(iCpuWe), .iCpuAddr(iCpuAddr), .iCpuData(iCpuData), .oCpuReady(oCpuReady),
      .iVgaReq(iVgaReq), .iVgaAddr(iVgaAddr), .oVgaData(oVgaData), .oVgaValid(oVgaValid),
      .oRamAddr(oRamAddr), .oRamData(oRamData), .oRamWe(oRamWe), .iRamData(iRamData),
      .iClear(iClear), .iClearColor(iClearColor), .oClearBusy(oClearBusy)
   );

   // 10 ns clock; inputs change and outputs are sampled around the falling edge.
   always #5 clock = ~clock;

   // Video RAM macro stand-in: synchronous read-before-write, not reset.
   logic [DATA_W-1:0] ram [MEM_N];
   always @(posedge clock) begin
      if (oRamWe) ram[oRamAddr] <= oRamData;
      iRamData <= ram[oRamAddr];
   end

   // Reference model: pending CPU writes in issue order, the memory image the
   // RAM should hold, and the clear-screen progress.
   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } wr_t;

   wr_t               pendQ[$];
   logic [DATA_W-1:0] refMem [MEM_N];
   bit                prevReq;
   logic [DATA_W-1:0] prevData;
   int                clrPhase;
   int                fillAddr;
   logic [DATA_W-1:0] clrColor;

   int checks = 0;
   int passes = 0;

   logic              lastReady;
   logic              lastWe;
   logic [ADDR_W-1:0] lastAddr;
   logic [DATA_W-1:0] lastData;
   logic              lastValid;
   logic [DATA_W-1:0] lastVgaData;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual == expected) passes++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   // One full cycle: drive inputs, compare every output with the model,
   // then advance the model by what that cycle should have done.
   task automatic applyStimulus(input bit we, input int a, input int d,
                                input bit vreq, input int va,
                                input bit clr, input int cc);
      bit                expReady, expWe, expValid, fromQ, fromFill;
      logic [ADDR_W-1:0] expAddr;
      logic [DATA_W-1:0] expData, expVga;
      int                startSize, startPhase;
      wr_t               w;
      @(negedge clock);
      iCpuWe      = we;
      iCpuAddr    = ADDR_W'(a);
      iCpuData    = DATA_W'(d);
      iVgaReq     = vreq;
      iVgaAddr    = ADDR_W'(va);
      iClear      = clr;
      iClearColor = DATA_W'(cc);
      #1;
      startSize  = pendQ.size();
      startPhase = clrPhase;
      expReady   = (startSize < DEPTH) && (startPhase == 0);
      fromQ      = 1'b0;
      fromFill   = 1'b0;
      expWe      = 1'b0;
      expAddr    = '0;
      expData    = '0;
      if (vreq) begin
         expAddr = ADDR_W'(va);
      end else if (startSize > 0) begin
         fromQ   = 1'b1;
         expWe   = 1'b1;
         expAddr = pendQ[0].a;
         expData = pendQ[0].d;
      end else if (startPhase == 2) begin
         fromFill = 1'b1;
         expWe    = 1'b1;
         expAddr  = ADDR_W'(fillAddr);
         expData  = clrColor;
      end
      expValid = prevReq;
      expVga   = prevReq ? prevData : '0;

      lastReady   = oCpuReady;
      lastWe      = oRamWe;
      lastAddr    = oRamAddr;
      lastData    = oRamData;
      lastValid   = oVgaValid;
      lastVgaData = oVgaData;

      checkOutput("cpu_ready", oCpuReady, expReady);
      checkOutput("ram_we", oRamWe, expWe);
      checkOutput("ram_addr", oRamAddr, expAddr);
      if (expWe) checkOutput("ram_data", oRamData, expData);
      checkOutput("vga_valid", oVgaValid, expValid);
      checkOutput("vga_data", oVgaData, expVga);
      checkOutput("clear_busy", oClearBusy, (startPhase != 0));

      if (vreq) prevData = refMem[va];
      prevReq = vreq;
      if (fromQ) begin
         w = pendQ.pop_front();
         refMem[w.a] = w.d;
      end
      if (fromFill) begin
         refMem[fillAddr] = clrColor;
         if (fillAddr == MEM_N - 1) clrPhase = 0;
         fillAddr = (fillAddr + 1) % MEM_N;
      end
      if (HAS_CLEAR) begin
         if (startPhase == 0 && clr) begin
            clrPhase = 1;
            clrColor = DATA_W'(cc);
            fillAddr = 0;
         end else if (startPhase == 1 && startSize == 0) begin
            clrPhase = 2;
         end
      end
      if (we && expReady) pendQ.push_back({ADDR_W'(a), DATA_W'(d)});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
   endtask

   // Asynchronous reset asserted at the falling edge: outputs must be at
   // their reset values before any clock edge follows.
   task automatic applyReset();
      @(negedge clock);
      reset   = 1'b1;
      iCpuWe  = 1'b0;
      iVgaReq = 1'b0;
      iClear  = 1'b0;
      #1;
      checkOutput("rst_ram_we", oRamWe, 0);
      checkOutput("rst_cpu_ready", oCpuReady, 1);
      checkOutput("rst_vga_valid", oVgaValid, 0);
      checkOutput("rst_vga_data", oVgaData, 0);
      checkOutput("rst_clear_busy", oClearBusy, 0);
      pendQ.delete();
      prevReq  = 1'b0;
      clrPhase = 0;
      fillAddr = 0;
      @(negedge clock);
      reset = 1'b0;
   endtask

   typedef struct {
      bit we; int a; int d; bit vreq; int va;
      bit eWe; int eAddr; int eData; bit eReady; bit eValid; int eVga;
   } vec_t;

   vec_t vecs[11];

   initial begin
      int k;
      int n;
      for (int i = 0; i < MEM_N; i++) begin
         ram[i]    = '0;
         refMem[i] = '0;
      end
      prevReq  = 1'b0;
      prevData = '0;
      clrPhase = 0;
      fillAddr = 0;
      clrColor = '0;

      vecs[0]  = '{1, 5, 2, 0, 0,   0, 0, 0, 1, 0, 0};
      vecs[1]  = '{1, 6, 4, 0, 0,   1, 5, 2, 1, 0, 0};
      vecs[2]  = '{0, 0, 0, 0, 0,   1, 6, 4, 1, 0, 0};
      vecs[3]  = '{1, 7, 1, 0, 0,   0, 0, 0, 1, 0, 0};
      vecs[4]  = '{0, 0, 0, 0, 0,   1, 7, 1, 1, 0, 0};
      vecs[5]  = '{0, 0, 0, 1, 7,   0, 7, 0, 1, 0, 0};
      vecs[6]  = '{0, 0, 0, 0, 0,   0, 0, 0, 1, 1, 1};
      vecs[7]  = '{0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0};
      vecs[8]  = '{0, 0, 0, 1, 5,   0, 5, 0, 1, 0, 0};
      vecs[9]  = '{0, 0, 0, 1, 6,   0, 6, 0, 1, 1, 2};
      vecs[10] = '{0, 0, 0, 0, 0,   0, 0, 0, 1, 1, 4};

      applyReset();

      $display("[TB] directed vectors");
      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].we, vecs[i].a, vecs[i].d, vecs[i].vreq, vecs[i].va, 0, 0);
         checkOutput($sformatf("vec%0d_we", i), lastWe, vecs[i].eWe);
         checkOutput($sformatf("vec%0d_addr", i), lastAddr, vecs[i].eAddr);
         if (vecs[i].eWe) checkOutput($sformatf("vec%0d_data", i), lastData, vecs[i].eData);
         checkOutput($sformatf("vec%0d_ready", i), lastReady, vecs[i].eReady);
         checkOutput($sformatf("vec%0d_valid", i), lastValid, vecs[i].eValid);
         checkOutput($sformatf("vec%0d_vga", i), lastVgaData, vecs[i].eVga);
      end

      $display("[TB] starvation under continuous VGA reads");
      k = 0;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1, 200 + k, k + 1, 1, i, 0, 0);
         if (lastReady) k++;
      end
      checkOutput("starve_accepted", k, 4);
      checkOutput("starve_ready_low", lastReady, 0);
      n = 0;
      while (k < 6 && n < 20) begin
         applyStimulus(1, 200 + k, k + 1, 0, 0, 0, 0);
         if (lastReady) k++;
         n++;
      end
      checkOutput("starve_all_accepted", k, 6);
      idle(DEPTH + 2);
      checkOutput("starve_mem_first", refMem[200], 1);
      checkOutput("starve_mem_last", refMem[205], 6);

      $display("[TB] steady enqueue and drain across pointer wrap");
      applyStimulus(1, 300, 1, 1, 0, 0, 0);
      applyStimulus(1, 301, 2, 1, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1, 302 + i, (i + 3) % 8, 0, 0, 0, 0);
         checkOutput("wrap_ready", lastReady, 1);
         checkOutput("wrap_count", pendQ.size(), 2);
      end
      idle(4);

      $display("[TB] reset with three writes queued");
      applyStimulus(1, 400, 7, 1, 0, 0, 0);
      applyStimulus(1, 401, 7, 1, 0, 0, 0);
      applyStimulus(1, 402, 7, 1, 0, 0, 0);
      applyReset();
      idle(4);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 600; i++) begin
         applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 63), $urandom_range(0, 7),
                       $urandom_range(0, 1), $urandom_range(0, 63),
                       HAS_CLEAR ? 1'b0 : 1'($urandom_range(0, 1)), $urandom_range(0, 7));
      end
      idle(DEPTH + 2);
      checkOutput("rand_drained", pendQ.size(), 0);

`ifdef VIDMEM_CLEAR_EN
      $display("[TB] clear screen");
      applyStimulus(1, 40, 5, 1, 0, 0, 0);
      applyStimulus(1, 41, 6, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 2);
      n = 0;
      while (clrPhase != 0 && n < 1500) begin
         applyStimulus(1, 30, 3, $urandom_range(0, 3) == 0, $urandom_range(0, 1023), 0, 0);
         n++;
      end
      checkOutput("clear_finished", clrPhase, 0);
      checkOutput("clear_mem_0", refMem[0], 2);
      checkOutput("clear_mem_40", refMem[40], 2);
      checkOutput("clear_mem_1023", refMem[1023], 2);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("clear_busy_fell", lastReady, 1);
      applyStimulus(1, 30, 5, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 30, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("clear_read30_valid", lastValid, 1);
      checkOutput("clear_read30_data", lastVgaData, 5);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
